// File: rtl/sha_mem_responder.sv
// Word-addressed memory slave for the SHA core bus with a host preload/readback port.
// Optional even-parity protection per word is enabled by defining PARITY_CHECK_EN.
module sha_mem_responder #(
   parameter int unsigned DEPTH    = 1024,
   parameter logic [31:0] OOR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        done,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [15:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic        host_gnt,
   output logic        host_rvalid,
   output logic [31:0] host_rdata,
   output logic        busy,
   output logic [15:0] wr_count,
   output logic        err_oor,
   input  logic        err_clr
`ifdef PARITY_CHECK_EN
   ,
   output logic        err_par,
   input  logic        inject_par
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {HOST, CORE_ARM, CORE_RUN} state_t;

   state_t      state;
   logic [31:0] mem [DEPTH];

   logic          core_own, core_in, host_in;
   logic          core_wr, host_wr, host_rd, oor_hit;
   logic [AW-1:0] core_idx, host_idx, wr_idx;
   logic          wr_en;
   logic [31:0]   wr_data;

   always_comb begin
      core_own = (state != HOST);
      core_in  = (32'(mem_addr) < DEPTH);
      host_in  = (32'(host_addr) < DEPTH);
      core_idx = mem_addr[AW-1:0];
      host_idx = host_addr[AW-1:0];
      host_gnt = (state == HOST) && host_req;
      host_rd  = host_gnt && !host_we;
      core_wr  = core_own && mem_we && core_in;
      host_wr  = host_gnt && host_we && host_in;
      // the core samples mem_addr every cycle it owns memory, so an OOR address counts as an access
      oor_hit  = (host_gnt && !host_in) || (core_own && !core_in);
      wr_en    = core_wr || host_wr;
      wr_idx   = core_wr ? core_idx : host_idx;
      wr_data  = core_wr ? mem_write_data : host_wdata;
   end

   // Storage is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= HOST;
         busy          <= 1'b0;
         mem_read_data <= '0;
         host_rdata    <= '0;
         host_rvalid   <= 1'b0;
         wr_count      <= '0;
         err_oor       <= 1'b0;
      end else begin
         host_rvalid <= host_rd;
         if (host_rd) host_rdata <= host_in ? mem[host_idx] : OOR_DATA;
         if (core_own) mem_read_data <= core_in ? mem[core_idx] : OOR_DATA;

         if (err_clr)      err_oor <= 1'b0;
         else if (oor_hit) err_oor <= 1'b1;

         if (state == HOST) begin
            if (start) wr_count <= '0;
         end else if (core_wr && wr_count != '1) begin
            wr_count <= wr_count + 16'd1;
         end

         case (state)
            HOST: begin
               if (start) begin
                  state <= CORE_ARM;
                  busy  <= 1'b1;
               end
            end
            // the core may still present done=1 the cycle after start
            CORE_ARM: begin
               if (!done) state <= CORE_RUN;
            end
            CORE_RUN: begin
               if (done) begin
                  state <= HOST;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= HOST;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PARITY_CHECK_EN
   logic par_mem [DEPTH];
   logic par_bad;

   always_comb begin
      par_bad = (host_rd && host_in && ((^mem[host_idx]) != par_mem[host_idx]))
             || (core_own && core_in && ((^mem[core_idx]) != par_mem[core_idx]));
   end

   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_idx] <= (^wr_data) ^ inject_par;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     err_par <= 1'b0;
      else if (err_clr) err_par <= 1'b0;
      else if (par_bad) err_par <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed + randomized bench for sha_mem_responder against an array-based memory model.
module tb_sha_mem_responder;

   localparam int unsigned DEPTH    = 1024;
   localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;

   logic        clk, reset_n, start, done, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data, mem_read_data;
   logic        host_req, host_we, host_gnt, host_rvalid;
   logic [15:0] host_addr;
   logic [31:0] host_wdata, host_rdata;
   logic        busy, err_oor, err_clr;
   logic [15:0] wr_count;
`ifdef PARITY_CHECK_EN
   logic        err_par, inject_par;
`endif

   sha_mem_responder #(.DEPTH(DEPTH), .OOR_DATA(OOR_DATA)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .done(done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata), .busy(busy), .wr_count(wr_count),
      .err_oor(err_oor), .err_clr(err_clr)
`ifdef PARITY_CHECK_EN
      , .err_par(err_par), .inject_par(inject_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] model [DEPTH];
   int checks   = 0;
   int failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [15:0] a, input logic [31:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      #1;
      chk("host_gnt_wr", 32'(host_gnt), 32'd1);
      tick();
      host_req = 1'b0; host_we = 1'b0;
      if (32'(a) < DEPTH) model[a] = d;
   endtask

   task automatic host_read(input string tag, input logic [15:0] a);
      host_req = 1'b1; host_we = 1'b0; host_addr = a;
      #1;
      chk("host_gnt_rd", 32'(host_gnt), 32'd1);
      tick();
      host_req = 1'b0;
      chk("host_rvalid", 32'(host_rvalid), 32'd1);
      chk(tag, host_rdata, (32'(a) < DEPTH) ? model[a] : OOR_DATA);
   endtask

   task automatic begin_session();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      done = 1'b0;
      tick();
   endtask

   task automatic end_session();
      mem_we = 1'b0;
      done = 1'b1;
      tick();
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] exp_count;
      logic [31:0] old;

      reset_n = 1'b0; start = 1'b0; done = 1'b1; mem_we = 1'b0;
      mem_addr = '0; mem_write_data = '0; host_req = 1'b0; host_we = 1'b0;
      host_addr = '0; host_wdata = '0; err_clr = 1'b0;
`ifdef PARITY_CHECK_EN
      inject_par = 1'b0;
`endif
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_read_data", mem_read_data, 32'd0);
      chk("rst_host_rdata", host_rdata, 32'd0);
      chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      chk("rst_err_oor", 32'(err_oor), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // host write/read, back-to-back reads, top-of-range word
      host_write(16'h0010, 32'h61626380);
      host_read("rd_0010", 16'h0010);
      tick();
      chk("rvalid_drops", 32'(host_rvalid), 32'd0);
      host_write(16'h03FF, 32'hA5A55A5A);
      host_read("rd_b2b_a", 16'h0010);
      host_read("rd_b2b_b", 16'h03FF);
      chk("err_oor_inrange", 32'(err_oor), 32'd0);

      for (int i = 0; i < 64; i++) host_write(16'h0200 + 16'(i), $urandom);
      for (int i = 0; i < 40; i++) begin
         a = 16'h0200 + 16'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) host_write(a, $urandom);
         else host_read("rand_host_rd", a);
      end

      // core session: read then 16 writes
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
      #1;
      chk("gnt_blocked", 32'(host_gnt), 32'd0);
      host_req = 1'b0;
      done = 1'b0; mem_addr = 16'h0010;
      tick();
      chk("core_rd_0010", mem_read_data, 32'h61626380);
      for (int i = 0; i < 16; i++) begin
         mem_we = 1'b1; mem_addr = 16'h0100 + 16'(i); mem_write_data = $urandom;
         tick();
         model[mem_addr] = mem_write_data;
      end
      mem_we = 1'b0; mem_addr = 16'h0010;
      end_session();
      chk("wr_count_16", 32'(wr_count), 32'd16);
      host_read("rd_0105", 16'h0105);

      // out-of-range host access and clear priority
      host_read("rd_oor", 16'h0400);
      chk("err_oor_set", 32'(err_oor), 32'd1);
      err_clr = 1'b1;
      host_write(16'h0500, 32'h12345678);
      err_clr = 1'b0;
      chk("err_clr_prio", 32'(err_oor), 32'd0);
      tick();
      chk("err_stays_clr", 32'(err_oor), 32'd0);

      // simultaneous host write and start, then random core traffic
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 32'hCAFEF00D;
      start = 1'b1;
      #1;
      chk("gnt_with_start", 32'(host_gnt), 32'd1);
      tick();
      model[16'h0020] = 32'hCAFEF00D;
      host_req = 1'b0; host_we = 1'b0; start = 1'b0;
      chk("busy_sim_start", 32'(busy), 32'd1);
      mem_addr = 16'h0200;
      done = 1'b0;
      tick();
      exp_count = 0;
      for (int i = 0; i < 60; i++) begin
         a = 16'h0200 + 16'($urandom_range(0, 63));
         d = $urandom;
         old = model[a];
         mem_addr = a; mem_write_data = d; mem_we = ($urandom_range(0, 1) == 1);
         tick();
         chk("core_rbw", mem_read_data, old);
         if (mem_we) begin
            model[a] = d;
            exp_count++;
         end
      end
      mem_we = 1'b1; mem_addr = 16'h07FF; mem_write_data = 32'h0BAD0BAD;
      tick();
      chk("core_oor_rd", mem_read_data, OOR_DATA);
      chk("core_oor_err", 32'(err_oor), 32'd1);
      chk("core_oor_nocount", 32'(wr_count), exp_count);
      mem_we = 1'b0; mem_addr = 16'h0200;
      end_session();
      chk("wr_count_rand", 32'(wr_count), exp_count);
      host_read("rd_0020", 16'h0020);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared", 32'(err_oor), 32'd0);
      for (int i = 0; i < 10; i++) host_read("rd_pool", 16'h0200 + 16'($urandom_range(0, 63)));

      // saturation of wr_count
      mem_addr = 16'h0005;
      begin_session();
      mem_we = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         mem_write_data = 32'(i);
         tick();
      end
      model[16'h0005] = 32'd65536;
      chk("wr_count_sat", 32'(wr_count), 32'h0000FFFF);
      end_session();
      host_read("rd_0005", 16'h0005);

      // reset in the middle of a core session
      mem_addr = 16'h0030;
      begin_session();
      mem_we = 1'b1; mem_write_data = 32'h31415926;
      tick();
      model[16'h0030] = 32'h31415926;
      mem_we = 1'b0;
      chk("wr_count_pre_rst", 32'(wr_count), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_wr_count", 32'(wr_count), 32'd0);
      chk("rst_mid_rvalid", 32'(host_rvalid), 32'd0);
      done = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030;
      #1;
      chk("gnt_after_rst", 32'(host_gnt), 32'd1);
      tick();
      host_req = 1'b0;
      chk("rd_0030_rvalid", 32'(host_rvalid), 32'd1);
      chk("rd_0030", host_rdata, model[16'h0030]);
      host_read("rd_0010_kept", 16'h0010);
      host_read("rd_0105_kept", 16'h0105);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
